// File: rtl/memwb.sv
// memwb: memory/writeback stage accepting committed ops from execute, driving a req/ack bus and the register-file write port
module memwb #(
  parameter int RW = 16,
  parameter int REGNO = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_ready,
  input  logic             i_submit,
  input  logic [RW-1:0]    i_data,
  input  logic [RW-1:0]    i_addr,
  input  logic [REGNO-1:0] i_reg_ie,
  input  logic             i_mem_access,
  input  logic             i_mem_we,
  output logic [REGNO-1:0] o_reg_ie,
  output logic [RW-1:0]    o_reg_data,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [RW-1:0]    o_mem_addr,
  output logic [RW-1:0]    o_mem_data,
  input  logic             i_mem_ack,
  input  logic [RW-1:0]    i_mem_data
);
  typedef enum logic [1:0] {IDLE, WB, MEM} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] data_q, data_d, addr_q, addr_d;
  logic [REGNO-1:0] reg_ie_q, reg_ie_d;
  logic we_q, we_d, accept;
  assign o_ready = state_q != MEM;
  assign accept = i_submit & o_ready;
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    addr_d = addr_q;
    reg_ie_d = reg_ie_q;
    we_d = we_q;
    if (accept) begin
      state_d = i_mem_access ? MEM : WB;
      data_d = i_data;
      addr_d = i_addr;
      // stores never write the register file
      reg_ie_d = (i_mem_access & i_mem_we) ? '0 : i_reg_ie;
      we_d = i_mem_access & i_mem_we;
    end else if (state_q == WB) begin
      state_d = IDLE;
    end else if (state_q == MEM && i_mem_ack) begin
      state_d = WB;
      data_d = we_q ? data_q : i_mem_data;
    end
  end
  always_ff @(posedge i_clk) begin
    state_q <= i_rst ? IDLE : state_d;
    we_q <= i_rst ? 1'b0 : we_d;
    reg_ie_q <= i_rst ? '0 : reg_ie_d;
    data_q <= data_d;
    addr_q <= addr_d;
  end
  assign o_reg_ie = (state_q == WB) ? reg_ie_q : '0;
  assign o_reg_data = data_q;
  assign o_mem_req = state_q == MEM;
  assign o_mem_we = (state_q == MEM) & we_q;
  assign o_mem_addr = addr_q;
  assign o_mem_data = data_q;
endmodule

// File: tb/tb_memwb.sv
// tb_memwb: directed-vector bench for the memory/writeback stage
module tb_memwb;
  logic clk = 0, rst = 0, ready, submit = 0, mem_access = 0, mem_we = 0;
  logic mem_req, omem_we, mem_ack = 0;
  logic [15:0] data = 0, addr = 0, reg_data, mem_addr, mem_wdata, mem_rdata = 0;
  logic [7:0] reg_ie = 0, oreg_ie;
  int n = 0, errs = 0;
  memwb dut (
    .i_clk(clk), .i_rst(rst), .o_ready(ready), .i_submit(submit),
    .i_data(data), .i_addr(addr), .i_reg_ie(reg_ie), .i_mem_access(mem_access),
    .i_mem_we(mem_we), .o_reg_ie(oreg_ie), .o_reg_data(reg_data),
    .o_mem_req(mem_req), .o_mem_we(omem_we), .o_mem_addr(mem_addr),
    .o_mem_data(mem_wdata), .i_mem_ack(mem_ack), .i_mem_data(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [15:0] d, input logic [15:0] a, input logic [7:0] ie, input logic m, input logic w);
    submit = 1; data = d; addr = a; reg_ie = ie; mem_access = m; mem_we = w;
  endtask
  initial begin
    rst = 1; step(); step(); rst = 0;
    chk("rst_ready", ready, 1); chk("rst_reg_ie", oreg_ie, 0);
    chk("rst_req", mem_req, 0); chk("rst_we", omem_we, 0);
    op(16'h1234, 16'h0, 8'h04, 0, 0); step(); submit = 0;
    chk("t1_ie", oreg_ie, 8'h04); chk("t1_data", reg_data, 16'h1234); chk("t1_ready", ready, 1);
    step(); chk("t1_ie_off", oreg_ie, 0);
    op(16'h0001, 16'h0, 8'h02, 0, 0); step();
    chk("t2_ie1", oreg_ie, 8'h02); chk("t2_d1", reg_data, 16'h0001); chk("t2_rdy1", ready, 1);
    op(16'h0002, 16'h0, 8'h04, 0, 0); step();
    chk("t2_ie2", oreg_ie, 8'h04); chk("t2_d2", reg_data, 16'h0002); chk("t2_rdy2", ready, 1);
    op(16'h0003, 16'h0, 8'h08, 0, 0); step(); submit = 0;
    chk("t2_ie3", oreg_ie, 8'h08); chk("t2_d3", reg_data, 16'h0003);
    step(); chk("t2_ie_off", oreg_ie, 0);
    op(16'h0000, 16'h0040, 8'h01, 1, 0); step(); submit = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_req", mem_req, 1); chk("t3_we", omem_we, 0);
      chk("t3_addr", mem_addr, 16'h0040); chk("t3_ready", ready, 0); chk("t3_ie", oreg_ie, 0);
      if (i == 3) begin mem_ack = 1; mem_rdata = 16'hBEEF; end
      step();
    end
    mem_ack = 0;
    chk("t3_wb_ie", oreg_ie, 8'h01); chk("t3_wb_data", reg_data, 16'hBEEF);
    chk("t3_wb_ready", ready, 1); chk("t3_wb_req", mem_req, 0);
    step(); chk("t3_ie_off", oreg_ie, 0);
    op(16'h00AA, 16'h0100, 8'h10, 1, 1); step(); submit = 0;
    chk("t4_req", mem_req, 1); chk("t4_we", omem_we, 1);
    chk("t4_wdata", mem_wdata, 16'h00AA); chk("t4_addr", mem_addr, 16'h0100); chk("t4_ready", ready, 0);
    mem_ack = 1; mem_rdata = 16'hDEAD; step(); mem_ack = 0;
    chk("t4_ie", oreg_ie, 0); chk("t4_ready2", ready, 1); chk("t4_req2", mem_req, 0); chk("t4_we2", omem_we, 0);
    op(16'h0000, 16'h0080, 8'h20, 1, 0); step();
    op(16'h5555, 16'h0011, 8'h40, 0, 0); step();
    chk("t5_ready", ready, 0); chk("t5_req", mem_req, 1); chk("t5_addr", mem_addr, 16'h0080); chk("t5_ie", oreg_ie, 0);
    mem_ack = 1; mem_rdata = 16'h7777; step(); mem_ack = 0;
    chk("t5_wb_ie", oreg_ie, 8'h20); chk("t5_wb_data", reg_data, 16'h7777); chk("t5_ready2", ready, 1);
    step(); submit = 0;
    chk("t5_new_ie", oreg_ie, 8'h40); chk("t5_new_data", reg_data, 16'h5555); chk("t5_new_req", mem_req, 0);
    step(); chk("t5_idle_ie", oreg_ie, 0);
    mem_ack = 1; mem_rdata = 16'h9999; step(); mem_ack = 0;
    chk("t5_stray_ie", oreg_ie, 0); chk("t5_stray_req", mem_req, 0);
    step(); chk("t5_stray_ie2", oreg_ie, 0);
    op(16'h0000, 16'h0020, 8'h02, 1, 0); step(); submit = 0;
    chk("t6_req", mem_req, 1);
    step(); rst = 1; step(); rst = 0;
    chk("t6_req0", mem_req, 0); chk("t6_ready", ready, 1); chk("t6_ie", oreg_ie, 0); chk("t6_we", omem_we, 0);
    mem_ack = 1; mem_rdata = 16'h1111; step(); mem_ack = 0;
    chk("t6_late_ie", oreg_ie, 0); chk("t6_late_req", mem_req, 0);
    step(); chk("t6_late_ie2", oreg_ie, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
